// File: rtl/eth_fifo_pkg.sv
// Shared defaults and elaboration helpers for the Ethernet MAC-to-host FIFO.
package eth_fifo_pkg;

  localparam int unsigned FIFO_DW    = 32;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_AW    = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

  localparam bit FIFO_AW_OK = (FIFO_AW == clog2(FIFO_DEPTH));

endpackage

// File: rtl/eth_dist_ram_dp.sv
// DEPTH x DW distributed storage: clocked write port, asynchronous read port.
module eth_dist_ram_dp
  import eth_fifo_pkg::*;
#(
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned AW    = FIFO_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are deliberately never reset; stale words are harmless behind empty.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/eth_fifo_rd_ctrl.sv
// Show-ahead FIFO between the MAC datapath and the host/DMA read handshake.
// Optional level / almost_full ports are enabled by defining ETH_FIFO_LEVEL_EN.
module eth_fifo_rd_ctrl
  import eth_fifo_pkg::*;
#(
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned AW    = FIFO_AW
`ifdef ETH_FIFO_LEVEL_EN
  ,
  parameter int unsigned ALMOST_FULL_MARGIN = 2
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          overflow,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
`ifdef ETH_FIFO_LEVEL_EN
  output logic [AW:0]   level,
  output logic          almost_full,
`endif
  output logic          empty
);

  if (!FIFO_AW_OK || AW != clog2(DEPTH) || DEPTH < 2) begin : g_bad_cfg
    $error("eth_fifo_rd_ctrl: AW must equal clog2(DEPTH) and DEPTH must be >= 2");
  end

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, flush;

  // Flags come only from registered count so rd_valid never sees rd_ready.
  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign rd_valid = ~empty;
  assign overflow = overflow_q;

  assign flush = reset | clear;
  assign push  = wr_en & ~full;
  assign pop   = rd_ready & rd_valid;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en & full;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // A write coinciding with reset/clear is dropped so the flush is clean.
  eth_dist_ram_dp #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

`ifdef ETH_FIFO_LEVEL_EN
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - ALMOST_FULL_MARGIN);

  assign level       = count_q;
  assign almost_full = (count_q >= AFULL_CNT);
`endif

endmodule
